counter_ctrl: RTL and testbench
===============================

COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, width of the shared counter value and of each tick request.
REQ-002 Parameter NREQ, default 4, number of requesters sharing the counter (2..8).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  NREQ  per-requester interval request.
REQ-006 req_ticks  input  NREQ*WIDTH  packed tick counts; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 req_ready  output  NREQ  one-hot grant/accept strobe.
REQ-008 done  output  NREQ  one-cycle completion pulse to the owning requester.
REQ-009 busy  output  1  high whenever the FSM is not IDLE.
REQ-010 cnt_en  output  1  drives the shared counter's enable input.
REQ-011 count  input  WIDTH  current value of the shared free-running counter (not clearable by this block).
REQ-012 abort  input  1  cancels the active interval.
REQ-013 err  output  1  one-cycle watchdog error pulse (tied 0 when watchdog is compiled out).

Function
REQ-014 The FSM SHALL have states IDLE, ARM, RUN and DONE.
REQ-015 In IDLE, when any req_valid is set, the round-robin arbiter SHALL select one requester starting from the priority pointer, and req_ready SHALL be asserted combinationally for it in that same cycle.
REQ-016 On accept, the FSM SHALL latch the requester id and its ticks, then go to ARM (ticks!=0) or directly to DONE (ticks==0, cnt_en never asserted).
REQ-017 In ARM, the FSM SHALL assert cnt_en, snapshot base=count and go to RUN.
REQ-018 In RUN, elapsed=(count-base) mod 2^WIDTH; cnt_en=(elapsed!=ticks); the FSM SHALL go to DONE when elapsed==ticks, so the counter advances exactly ticks steps.
REQ-019 Counter wrap-around SHALL be transparent via modulo subtraction; ticks up to 2^WIDTH-1 SHALL be supported.
REQ-020 In DONE, done[id] SHALL pulse for one cycle, the pointer SHALL advance to (id+1) mod NREQ, and the FSM SHALL return to IDLE.
REQ-021 Latency: accept in cycle 0, done pulse in cycle ticks+2 (cycle 1 when ticks==0), next accept no earlier than the following cycle.
REQ-022 Requesters SHALL hold req_valid and req_ticks stable until req_ready; the block SHALL ignore their changes after the latch.
REQ-023 abort in ARM or RUN SHALL force IDLE next cycle with cnt_en=0, no done pulse and the pointer advanced; abort SHALL win over a same-cycle elapsed==ticks match; abort in IDLE or DONE SHALL be ignored.

Reset
REQ-024 While rst_n is low: state=IDLE, pointer=0, latched id/ticks/base=0, and req_ready, done, busy, cnt_en, err all 0.
REQ-025 Reset mid-interval SHALL abandon the interval silently, with no done pulse after release.

Configuration
REQ-026 With COUNTER_CTRL_WDOG_EN defined, a watchdog SHALL count consecutive RUN cycles in which count is unchanged; on reaching WDOG_CYCLES it SHALL pulse err for one cycle and handle the interval exactly as an abort.
REQ-027 Without COUNTER_CTRL_WDOG_EN, no watchdog logic SHALL exist and err SHALL be constant 0.

Structure
REQ-028 Package counter_ctrl_pkg SHALL hold the state enum type and the constant WDOG_CYCLES=16.
REQ-029 Round-robin selection SHALL be a sub-module rr_arbiter (NREQ-wide request, pointer in, one-hot grant out).

Verification
REQ-030 Single request, ticks=5, base count=0x10 -> req_ready cycle 0, cnt_en high cycles 1-5, count stops at 0x15, done[0] in cycle 7.
REQ-031 Wrap: base count=0xFE, ticks=4 -> count stops at 0x02, done pulses once.
REQ-032 Requesters 0-3 all valid with ticks=2 -> grants in order 0,1,2,3,0, with no requester granted twice before all are served.
REQ-033 ticks=0 -> done in cycle 1 and cnt_en never high.
REQ-034 abort in the third RUN cycle of ticks=10 -> IDLE next cycle, no done, next grant goes to id+1.
REQ-035 rst_n low mid-RUN, then COUNTER_CTRL_WDOG_EN with count held (counter enable ignored) -> all outputs 0 during reset; then err pulse after 16 stalled RUN cycles with no done.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for counter_ctrl: FSM state encoding and the
// watchdog stall threshold (used only when COUNTER_CTRL_WDOG_EN is defined).
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Consecutive stalled RUN cycles before the watchdog fires.
    localparam int WDOG_CYCLES = 16;
    localparam int WDOG_W      = $clog2(WDOG_CYCLES + 1);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans requests starting at the priority pointer and
// returns a one-hot grant for the first active request found.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant
);

    int   idx;
    logic found;

    // Pick the first requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        // NOTE: every output of a combinational block gets a default up front,
        // otherwise paths that skip an assignment infer a latch.
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = (int'(ptr) + off) % NREQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: shares one free-running counter among NREQ requesters.
// A request for N ticks enables the counter for exactly N steps, measured
// by modulo subtraction from a snapshot so counter wrap is transparent.
// Optional stall watchdog: define COUNTER_CTRL_WDOG_EN to build it in.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_ticks,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  cnt_en,
    input  logic [WIDTH-1:0]      count,
    input  logic                  abort,
    output logic                  err
);

    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   id_q;
    logic [WIDTH-1:0]  ticks_q;
    logic [WIDTH-1:0]  base_q;
    logic [WIDTH-1:0]  elapsed;
    logic [NREQ-1:0]   grant;
    logic [ID_W-1:0]   grant_id;
    logic [WIDTH-1:0]  grant_ticks;
    logic              match;
    logic              wdog_trip;
    logic              cancel;

    // Priority rotates to the requester after the one last served.
    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == ID_W'(NREQ - 1)) ? '0 : id + 1'b1;
    endfunction

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    // Encode the one-hot grant into an index for latching id and ticks.
    always_comb begin
        grant_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) grant_id = ID_W'(i);
        end
    end

    assign grant_ticks = req_ticks[int'(grant_id) * WIDTH +: WIDTH];

    // Modulo subtraction keeps elapsed correct across counter wrap.
    assign elapsed = count - base_q;
    assign match   = (elapsed == ticks_q);

    // Accept strobe is combinational in IDLE; rst_n gates it so no grant
    // leaks out while the block is held in reset.
    assign req_ready = (state == IDLE && rst_n) ? grant : '0;

    // Counter runs in ARM and in RUN until the requested step count is reached.
    assign cnt_en = (state == ARM) || (state == RUN && !match);

    // Abort (or watchdog) only matters while an interval is counting.
    assign cancel = (state == ARM || state == RUN) && (abort || wdog_trip);

`ifdef COUNTER_CTRL_WDOG_EN
    logic [WIDTH-1:0]  prev_count;
    logic [WDOG_W-1:0] stall_cnt;
    logic [WDOG_W-1:0] stall_next;

    // Count consecutive RUN cycles in which the counter did not move.
    always_comb begin
        stall_next = '0;
        if (state == RUN && count == prev_count) stall_next = stall_cnt + 1'b1;
    end

    assign wdog_trip = (state == RUN) && (stall_next == WDOG_W'(WDOG_CYCLES));

    // Track the previous count and the stall run length; pulse err on trip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_count <= '0;
            stall_cnt  <= '0;
            err        <= 1'b0;
        end else begin
            prev_count <= count;
            stall_cnt  <= wdog_trip ? '0 : stall_next;
            err        <= wdog_trip;
        end
    end
`else
    assign wdog_trip = 1'b0;
    assign err       = 1'b0;
`endif

    // Interval FSM: accept, snapshot base, count, report completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            id_q    <= '0;
            ticks_q <= '0;
            base_q  <= '0;
            done    <= '0;
            busy    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            done <= '0;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        id_q    <= grant_id;
                        ticks_q <= grant_ticks;
                        busy    <= 1'b1;
                        if (grant_ticks == '0) begin
                            state <= DONE;
                            done  <= grant;
                        end else begin
                            state <= ARM;
                        end
                    end
                end
                ARM: begin
                    if (cancel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        ptr   <= next_id(id_q);
                    end else begin
                        base_q <= count;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (cancel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        ptr   <= next_id(id_q);
                    end else if (match) begin
                        state <= DONE;
                        done  <= NREQ'(1) << id_q;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ptr   <= next_id(id_q);
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: reset values, round-robin order,
// a table of single intervals (including wrap, ticks=0 and ticks=255),
// abort, reset mid-interval, stalled counter, and a randomized run checked
// against a transaction-level latency model.
module tb_counter_ctrl;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_ticks;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic                  cnt_en;
    logic [WIDTH-1:0]      count = '0;
    logic                  abort;
    logic                  err;

    logic                  hold;
    logic                  load_en;
    logic [WIDTH-1:0]      load_val;

    int checks = 0;
    int errors = 0;

    counter_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ticks (req_ticks),
        .req_ready (req_ready),
        .done      (done),
        .busy      (busy),
        .cnt_en    (cnt_en),
        .count     (count),
        .abort     (abort),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Shared free-running counter: loadable by the bench, stallable via hold.
    always @(posedge clk) begin
        if (load_en) count <= load_val;
        else if (cnt_en && !hold) count <= count + 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ticks(input int id, input int t);
        req_ticks[id*WIDTH +: WIDTH] = WIDTH'(t);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        check(name, 32'(ok), 1);
        tick();
    endtask

    typedef struct {
        int         id;
        int         ticks;
        logic [7:0] base;
        int         done_cyc;
        logic [7:0] final_cnt;
    } vec_t;

    vec_t vecs[5];
    int   rr_order[5];

    // Randomized-phase model state
    logic [NREQ-1:0] pend;
    int              pt[NREQ];
    int              m_ptr, m_id, m_t, m_acc, m_gid;
    bit              m_act;
    logic [7:0]      m_c0;

    int              ng, en_cnt, dcyc, rel, dlat, err_cnt, err_cyc;
    logic [NREQ-1:0] dval, exp_gnt, exp_done, seen_done;
    logic [7:0]      diff;
    bit              found, exp_en;

    initial begin
        vecs[0] = '{id: 0, ticks: 5,   base: 8'h10, done_cyc: 7,   final_cnt: 8'h15};
        vecs[1] = '{id: 1, ticks: 4,   base: 8'hFE, done_cyc: 6,   final_cnt: 8'h02};
        vecs[2] = '{id: 2, ticks: 0,   base: 8'h40, done_cyc: 1,   final_cnt: 8'h40};
        vecs[3] = '{id: 3, ticks: 1,   base: 8'h00, done_cyc: 3,   final_cnt: 8'h01};
        vecs[4] = '{id: 0, ticks: 255, base: 8'h01, done_cyc: 257, final_cnt: 8'h00};
        rr_order = '{0, 1, 2, 3, 0};

        req_valid = '0; req_ticks = '0; abort = 1'b0;
        hold = 1'b0; load_en = 1'b0; load_val = '0;

        // ---- reset values, with requests pending ----
        rst_n = 1'b0;
        req_valid = '1;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_cnt_en", 32'(cnt_en), 0);
        check("rst_err", 32'(err), 0);
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();

        // ---- round robin: all requesters continuously valid ----
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) set_ticks(i, 2);
        ng = 0;
        for (int c = 0; c < 100 && ng < 5; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                check("rr_order", 32'(req_ready), 32'(1) << rr_order[ng]);
                ng++;
            end
            tick();
        end
        req_valid = '0;
        check("rr_grant_count", 32'(ng), 5);
        wait_idle("rr_idle");

        // ---- table of single intervals ----
        for (int v = 0; v < 5; v++) begin
            load_val = vecs[v].base; load_en = 1'b1;
            tick();
            load_en = 1'b0;
            req_valid = NREQ'(1) << vecs[v].id;
            set_ticks(vecs[v].id, vecs[v].ticks);
            @(negedge clk);
            check("vec_ready", 32'(req_ready), 32'(1) << vecs[v].id);
            tick();
            req_valid = '0;
            req_ticks = NREQ*WIDTH'($urandom);
            en_cnt = 0; dcyc = -1; dval = '0;
            for (int c = 1; c <= 300 && dcyc < 0; c++) begin
                @(negedge clk);
                if (cnt_en) en_cnt++;
                if (done != '0) begin
                    dcyc = c; dval = done;
                end else begin
                    tick();
                end
            end
            check("vec_done_cycle", 32'(dcyc), 32'(vecs[v].done_cyc));
            check("vec_done_id", 32'(dval), 32'(1) << vecs[v].id);
            check("vec_cnt_en_cycles", 32'(en_cnt), 32'(vecs[v].ticks));
            check("vec_final_count", 32'(count), 32'(vecs[v].final_cnt));
            tick();
            @(negedge clk);
            check("vec_done_single", 32'(done), 0);
            check("vec_busy_after", 32'(busy), 0);
            check("vec_count_stopped", 32'(count), 32'(vecs[v].final_cnt));
            tick();
        end

        // ---- abort in third RUN cycle ----
        req_valid = 4'b0010;
        set_ticks(1, 10);
        @(negedge clk);
        check("abort_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        repeat (3) tick();
        abort = 1'b1;
        @(negedge clk);
        check("abort_busy_run", 32'(busy), 1);
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abort_idle_busy", 32'(busy), 0);
        check("abort_idle_cnt_en", 32'(cnt_en), 0);
        seen_done = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            seen_done |= done;
            tick();
        end
        check("abort_no_done", 32'(seen_done), 0);
        // next grant goes to id+1; abort while IDLE is ignored
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) set_ticks(i, 3);
        abort = 1'b1;
        @(negedge clk);
        check("abort_next_grant", 32'(req_ready), 32'h4);
        tick();
        abort = 1'b0;
        req_valid = '0;
        dval = '0;
        for (int c = 1; c <= 50 && dval == '0; c++) begin
            @(negedge clk);
            if (done != '0) dval = done;
            else tick();
        end
        check("abort_idle_ignored_done", 32'(dval), 32'h4);
        tick();
        wait_idle("abort_recover_idle");

        // ---- reset in the middle of RUN ----
        req_valid = 4'b0001;
        set_ticks(0, 10);
        @(negedge clk);
        check("rstmid_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        repeat (3) tick();
        rst_n = 1'b0;
        req_valid = 4'b0010;
        @(negedge clk);
        check("rstmid_req_ready", 32'(req_ready), 0);
        check("rstmid_done", 32'(done), 0);
        check("rstmid_busy", 32'(busy), 0);
        check("rstmid_cnt_en", 32'(cnt_en), 0);
        check("rstmid_err", 32'(err), 0);
        tick();
        rst_n = 1'b1;
        req_valid = '0;
        seen_done = '0;
        found = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            seen_done |= done;
            if (busy) found = 1'b1;
            tick();
        end
        check("rstmid_no_done", 32'(seen_done), 0);
        check("rstmid_stays_idle", 32'(found), 0);

        // ---- stalled counter (counter enable ignored) ----
        hold = 1'b1;
        req_valid = 4'b0001;
        set_ticks(0, 5);
        @(negedge clk);
        check("stall_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        err_cnt = 0; err_cyc = -1; seen_done = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (err) begin
                err_cnt++;
                if (err_cyc < 0) err_cyc = c;
            end
            seen_done |= done;
            tick();
        end
        check("stall_no_done", 32'(seen_done), 0);
`ifdef COUNTER_CTRL_WDOG_EN
        check("wdog_err_cycle", 32'(err_cyc), 18);
        check("wdog_err_pulses", 32'(err_cnt), 1);
        @(negedge clk);
        check("wdog_idle_after", 32'(busy), 0);
        tick();
`else
        check("stall_err_tied_low", 32'(err_cnt), 0);
        @(negedge clk);
        check("stall_still_busy", 32'(busy), 1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("stall_abort_idle", 32'(busy), 0);
        tick();
`endif
        hold = 1'b0;

        // ---- randomized traffic against a latency model ----
        rst_n = 1'b0;
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        pend = '0; m_ptr = 0; m_act = 1'b0; m_id = 0; m_t = 0; m_acc = 0; m_c0 = '0;
        for (int i = 0; i < NREQ; i++) pt[i] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        pend[i] = 1'b1;
                        pt[i] = $urandom_range(0, 6);
                    end else begin
                        pt[i] = $urandom_range(0, 255);
                    end
                end
                set_ticks(i, pt[i]);
            end
            req_valid = pend;
            abort = ($urandom_range(0, 15) == 0);
            @(negedge clk);

            exp_gnt = '0; found = 1'b0; m_gid = 0;
            if (!m_act) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (!found && pend[(m_ptr + k) % NREQ]) begin
                        found = 1'b1;
                        m_gid = (m_ptr + k) % NREQ;
                        exp_gnt = NREQ'(1) << m_gid;
                    end
                end
            end
            rel = n - m_acc;
            dlat = (m_t == 0) ? 1 : m_t + 2;
            exp_en = m_act && rel >= 1 && rel <= m_t;
            exp_done = (m_act && rel == dlat) ? NREQ'(1) << m_id : '0;

            check("rnd_req_ready", 32'(req_ready), 32'(exp_gnt));
            check("rnd_done", 32'(done), 32'(exp_done));
            check("rnd_busy", 32'(busy), 32'(m_act));
            check("rnd_cnt_en", 32'(cnt_en), 32'(exp_en));
            check("rnd_err", 32'(err), 0);
            if (exp_done != '0) begin
                diff = count - m_c0;
                check("rnd_count_advance", 32'(diff), 32'(m_t));
            end

            if (m_act) begin
                if (rel == dlat) begin
                    m_act = 1'b0;
                    m_ptr = (m_id + 1) % NREQ;
                end else if (abort && m_t > 0 && rel <= m_t + 1) begin
                    m_act = 1'b0;
                    m_ptr = (m_id + 1) % NREQ;
                end
            end else if (found) begin
                m_act = 1'b1;
                m_id = m_gid;
                m_t = pt[m_gid];
                m_acc = n;
                m_c0 = count;
                pend[m_gid] = 1'b0;
            end
            tick();
        end
        abort = 1'b0;
        req_valid = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
